// File: rtl/count_sched_pkg.sv
// Shared definitions for the round-robin scheduled down-counter.
package count_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COUNT,
      DONE
   } state_t;

   localparam int unsigned NREQ_DEF  = 4;
   localparam int unsigned WIDTH_DEF = 4;

endpackage

// File: rtl/down_counter_sync.sv
// Synchronous load/decrement/hold counter with asynchronous active-low clear.
module down_counter_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= din;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/count_sched.sv
// Round-robin arbiter that lends one shared down-counter to NREQ requesters.
module count_sched
   import count_sched_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] load_val,
   input  logic                  pause,
   output logic [NREQ-1:0]       grant,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic [NREQ-1:0]       done
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state, state_n;
   logic [NREQ-1:0] grant_n;
   logic [IW-1:0]   sel, sel_n, last, last_n, win;
   logic [WIDTH-1:0] lv [NREQ];
   logic            found, ld, dec;
   int unsigned     idx;

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign lv[g] = load_val[g*WIDTH +: WIDTH];
   end

   // First requester at or after last+1, wrapping modulo NREQ.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = (32'(last) + 1 + i) % NREQ;
         if (!found && req[IW'(idx)]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         sel   <= '0;
         last  <= IW'(NREQ - 1);
      end else begin
         state <= state_n;
         grant <= grant_n;
         sel   <= sel_n;
         last  <= last_n;
      end
   end

   // A dropped request outranks both loading and reaching zero.
   always_comb begin
      state_n = state;
      grant_n = grant;
      sel_n   = sel;
      last_n  = last;
      ld      = 1'b0;
      dec     = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               grant_n      = '0;
               grant_n[win] = 1'b1;
               sel_n        = win;
               state_n      = LOAD;
            end
         end
         LOAD: begin
            if (!req[sel]) begin
               grant_n = '0;
               state_n = IDLE;
            end else begin
               ld      = 1'b1;
               state_n = COUNT;
            end
         end
         COUNT: begin
            if (!req[sel]) begin
               grant_n = '0;
               state_n = IDLE;
            end else if (count == '0) begin
               state_n = DONE;
            end else if (!pause) begin
               dec = 1'b1;
            end
         end
         DONE: begin
            last_n  = sel;
            grant_n = '0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   down_counter_sync #(
      .WIDTH(WIDTH)
   ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .load (ld),
      .dec  (dec),
      .din  (lv[sel]),
      .count(count)
   );

   assign busy = (state != IDLE);
   assign done = (state == DONE) ? grant : '0;

endmodule

// File: tb/tb_count_sched.sv
// Directed and randomized transactions checked against a transaction-level model.
module tb_count_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int LW    = NREQ * WIDTH;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NREQ-1:0] req;
   logic [LW-1:0]   load_val;
   logic            pause;
   logic [NREQ-1:0] grant;
   logic [WIDTH-1:0] count;
   logic            busy;
   logic [NREQ-1:0] done;

   int n_assert = 0;
   int n_fail   = 0;
   int m_last;
   int m_count;

   count_sched #(
      .NREQ (NREQ),
      .WIDTH(WIDTH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .load_val(load_val),
      .pause   (pause),
      .grant   (grant),
      .count   (count),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] eg, input logic [31:0] ed,
                          input logic [31:0] eb, input logic [31:0] ec);
      chk({tag, " grant"}, 32'(grant), eg);
      chk({tag, " done"},  32'(done),  ed);
      chk({tag, " busy"},  32'(busy),  eb);
      chk({tag, " count"}, 32'(count), ec);
   endtask

   function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   // One grant-to-completion (or abort) transaction, predicted edge by edge.
   task automatic do_txn(input logic [NREQ-1:0] rq, input logic [LW-1:0] lv,
                         input logic [31:0] pmask, input int abort_cnt,
                         output logic [NREQ-1:0] g0);
      int w, cnt, k;
      logic p, ab, fin;
      logic [31:0] oh;
      w   = rr_pick(m_last, rq);
      oh  = 32'(1) << w;
      cnt = int'(lv[w*WIDTH +: WIDTH]);
      req = rq;
      load_val = lv;
      pause = 1'($urandom_range(0, 1));
      step();
      g0 = grant;
      chk_out("E0", oh, 0, 1, 32'(m_count));
      pause = 1'($urandom_range(0, 1));
      step();
      chk_out("E1", oh, 0, 1, 32'(cnt));
      load_val = LW'($urandom());
      k   = 0;
      fin = 1'b0;
      for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
         ab = (abort_cnt >= 0) && (cnt == abort_cnt);
         p  = (k < 32) ? pmask[k] : 1'b0;
         pause = p;
         if (ab) req[w] = 1'b0;
         step();
         if (ab) begin
            chk_out("abort", 0, 0, 0, 32'(cnt));
            m_count = cnt;
            fin = 1'b1;
         end else if (cnt == 0) begin
            chk_out("done", oh, oh, 1, 0);
            pause = 1'($urandom_range(0, 1));
            step();
            chk_out("post", 0, 0, 0, 0);
            m_last  = w;
            m_count = 0;
            fin = 1'b1;
         end else begin
            if (!p) cnt--;
            chk_out("count", oh, 0, 1, 32'(cnt));
         end
         k++;
      end
      if (!fin) chk("timeout", 32'(0), 32'(1));
      req   = '0;
      pause = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_out("rst", 0, 0, 0, 0);
      step();
      rst_n   = 1'b1;
      m_last  = NREQ - 1;
      m_count = 0;
   endtask

   initial begin
      logic [NREQ-1:0] g;
      logic [LW-1:0]   lv;
      logic [NREQ-1:0] rq;
      int              ab;
      rst_n    = 1'b0;
      req      = '0;
      pause    = 1'b0;
      load_val = '0;
      m_last   = NREQ - 1;
      m_count  = 0;
      repeat (2) step();
      chk_out("reset", 0, 0, 0, 0);
      rst_n = 1'b1;
      step();
      chk_out("idle", 0, 0, 0, 0);

      // Single request, L=3.
      lv = 16'h0003;
      do_txn(4'b0001, lv, 0, -1, g);
      chk("single g0", 32'(g), 32'h1);

      // Contention from reset: strict rotation.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         do_txn(4'b1111, LW'($urandom()), 0, -1, g);
         chk("rr order", 32'(g), 32'(1) << (i % NREQ));
      end

      // Pause for three COUNT cycles with L=5.
      do_txn(4'b0100, 16'h0500, 32'b11100, -1, g);
      chk("pause g0", 32'(g), 32'h4);

      // Zero load value; leaves last at 3.
      do_txn(4'b1000, 16'h0000, 0, -1, g);
      chk("zero g0", 32'(g), 32'h8);

      // Abort requester 2 at count 2; last stays 3 so requester 1 wins next.
      do_txn(4'b0100, 16'h0600, 0, 2, g);
      do_txn(4'b1010, LW'($urandom()), 0, -1, g);
      chk("abort next", 32'(g), 32'h2);

      // Reset at count 4.
      req = 4'b0001;
      load_val = 16'h0009;
      pause = 1'b0;
      step();
      chk("rm grant", 32'(grant), 32'h1);
      step();
      chk("rm load", 32'(count), 32'h9);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rm count", 32'(count), 32'(8 - i));
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("rm async", 0, 0, 0, 0);
      step();
      chk_out("rm held", 0, 0, 0, 0);
      rst_n   = 1'b1;
      m_last  = NREQ - 1;
      m_count = 0;
      do_txn(4'b1001, LW'($urandom()), 0, -1, g);
      chk("rm prio", 32'(g), 32'h1);

      // Randomized traffic.
      for (int t = 0; t < 30; t++) begin
         rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
         do_txn(rq, LW'($urandom()), $urandom() & $urandom(), ab, g);
         if ($urandom_range(0, 2) == 0) begin
            step();
            chk_out("gap", 0, 0, 0, 32'(m_count));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
